// File: rtl/uart8_rx_fifo_if.sv
// rtl/uart8_rx_fifo_if.sv - consumer-side byte stream (valid/ready) of the UART receive FIFO
interface uart8_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart8_rx_fifo.sv
// rtl/uart8_rx_fifo.sv - show-ahead byte FIFO behind the UART receiver
// with sticky overrun/framing status and a saturating dropped-byte counter.
module uart8_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_rx_err,
  uart8_rx_fifo_if.master       rd_if,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_overrun,
  output logic                  o_frame_err,
  output logic [7:0]            o_drop_count,
  input  logic                  i_err_clear
);
  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_done_q;
  logic                  r_err_q;
  logic                  r_overrun;
  logic                  r_frame_err;
  logic [7:0]            r_drop_count;

  logic w_push;
  logic w_frame;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_wr_ok;
  logic w_drop;

  assign w_push  = i_rx_done & ~r_done_q;
  assign w_frame = i_rx_err & ~r_err_q;
  assign w_full  = (r_count == C_DEPTH);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & rd_if.rd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_wr_ok = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign rd_if.rd_data  = r_mem[r_rd_ptr];
  assign rd_if.rd_valid = w_valid;
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_overrun      = r_overrun;
  assign o_frame_err    = r_frame_err;
  assign o_drop_count   = r_drop_count;

  // Edge detectors keep sampling while disabled so a strobe spanning en=0 is not replayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b0;
      r_err_q  <= 1'b0;
    end else begin
      r_done_q <= i_rx_done;
      r_err_q  <= i_rx_err;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en && w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_drop_count <= '0;
    end else if (!i_en) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      if (w_wr_ok && !w_pop) begin
        r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
      end else if (!w_wr_ok && w_pop) begin
        r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
      end

      // New events take priority over a coincident clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_err_clear) begin
        r_overrun <= 1'b0;
      end

      if (w_frame) begin
        r_frame_err <= 1'b1;
      end else if (i_err_clear) begin
        r_frame_err <= 1'b0;
      end

      if (w_drop) begin
        if (i_err_clear) begin
          r_drop_count <= 8'd1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end else if (i_err_clear) begin
        r_drop_count <= '0;
      end
    end
  end
endmodule

// File: doc/uart8_rx_fifo.md
Name: uart8_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the 8-bit UART receiver.
- Captures each completed byte on the receiver's done pulse into a show-ahead (first-word-fall-through) FIFO, and presents bytes to the consumer via a valid/ready handshake.
- Tracks sticky overrun and framing-error status, plus a saturating dropped-byte counter.
- Runs on the same clock that drives the receiver (16x-oversampled baud clock), so there is no CDC inside this block.

Parameters:
- DATA_WIDTH, 8: byte width; must match receiver output.
- DEPTH_LOG2, 4: log2 of FIFO depth (default 16 entries); legal range 1..8.

Ports:
- clk  in  1  clock; same clock as the receiver.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low = synchronous flush/hold-in-clear.
- rx_data  in  DATA_WIDTH  receiver byte output.
- rx_done  in  1  receiver end-of-byte strobe.
- rx_err  in  1  receiver error flag (level).
- rd_data  out  DATA_WIDTH  head-of-FIFO byte; valid only when rd_valid=1.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts head byte.
- count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- full  out  1  count == 2^DEPTH_LOG2.
- overrun  out  1  sticky: byte dropped because FIFO was full.
- frame_err  out  1  sticky: receiver reported an error.
- drop_count  out  8  saturating count of dropped bytes.
- err_clear  in  1  one-cycle pulse; clears overrun, frame_err and drop_count.

Behaviour:
- Reset (rst=1, async): rd_ptr=wr_ptr=0, count=0, rd_valid=0, full=0, overrun=0, frame_err=0, drop_count=0, edge-detect registers=0. rd_data is don't-care; memory is not cleared.
- Push event: rising edge of rx_done, i.e. rx_done=1 and the registered previous rx_done=0. A strobe held high for multiple cycles writes exactly once.
- Frame event: rising edge of rx_err, same edge-detect scheme.
- Pop event: rd_valid && rd_ready.
- Storage: 2^DEPTH_LOG2-entry register array. Pointers are DEPTH_LOG2 bits and wrap modulo depth. Occupancy is held in a separate count register.
- Read path:
  - rd_data = mem[rd_ptr] (combinational).
  - rd_valid = (count != 0).
  - A byte pushed at edge N is visible on rd_data/rd_valid in the cycle after edge N (1-cycle latency).
- Updates per clock edge when en=1:
  - Push only, not full: mem[wr_ptr] <= rx_data; wr_ptr++; count++.
  - Push only, full: byte discarded; overrun<=1; drop_count++ (saturates at 255); pointers and count unchanged.
  - Pop only: rd_ptr++; count--.
  - Push and pop, count between 1 and depth-1: both pointers advance; count unchanged.
  - Push and pop, full: pop frees a slot and the push is accepted; count stays at depth; no overrun.
  - Push while empty: rd_valid is 0, so no pop can occur; push accepted normally.
  - rd_ready while empty: ignored.
- Frame event: frame_err<=1. The byte stream is not affected; a later push is still stored.
- err_clear: clears overrun, frame_err and drop_count. If a new overrun or frame event occurs in the same cycle, the event wins: flag set, drop_count=1.
- en=0 (synchronous): pointers and count go to 0; overrun, frame_err and drop_count go to 0; edge detectors keep sampling. Push/pop are ignored while en=0, so a done edge during en=0 is lost. Normal operation resumes on the first edge with en=1.
- Reset asserted mid-operation: all state clears immediately; contents are treated as lost.
- full = (count == 2^DEPTH_LOG2).
- All outputs come from registers, except rd_data, rd_valid and full, which decode directly from the count/pointer registers.

Test Plan:
- Basic: reset, en=1; pulse rx_done with rx_data=0xA5, then 0x3C; hold rd_ready=0 -> rd_valid=1 one cycle after the first pulse, rd_data=0xA5, count=2; assert rd_ready for 2 cycles -> read 0xA5 then 0x3C, count=0, rd_valid=0.
- Overflow: DEPTH_LOG2=4; push 0x00..0x0F, then push 0x10 and 0x11 with no pop -> full=1, count=16, overrun=1, drop_count=2; drain yields exactly 0x00..0x0F in order; pulse err_clear -> overrun=0, drop_count=0.
- Full with simultaneous push/pop: fill 16 entries, then push 0x55 in the same cycle as a pop -> count stays 16, overrun=0; the final byte drained is 0x55.
- Wrap and long strobe: push/pop 40 bytes with pointer wrap-around, rx_done held high 3 cycles on one byte -> exact in-order output; the long strobe produces exactly one entry.
- Errors and flush: pulse rx_err -> frame_err=1 and FIFO contents unchanged; err_clear coincident with a new rx_err edge -> frame_err stays 1; drive en=0 for one cycle with count=5 -> count=0, rd_valid=0, all flags 0.
- Async reset: assert rst between clock edges with count=7 -> count=0 and rd_valid=0 immediately, before the next clock edge.
